io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Two-port arbiter that shares the 16-bit on-board I/O bus (8-bit local address, 16-bit write data, 16-bit combinational read data, single write-enable) between two requesters: port 0 (CPU) and port 1 (secondary master, e.g. a debug monitor or display sequencer). It sits between the masters and the basic I/O block. It serialises accesses through a three-state FSM and returns read data and a one-cycle acknowledge to the winning requester. Arbitration is round-robin, or fixed priority for port 0 when configured.

## Interface
- `FIXED_PRIORITY`, default 0: 0 = round-robin between ports; 1 = port 0 always wins a tie.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `m0_req` input 1: port 0 request; held high until `m0_ack`.
- `m0_we` input 1: port 0 access type; 1 = write, 0 = read. Stable while `m0_req` is high.
- `m0_addr` input 8: port 0 local address. Stable while `m0_req` is high.
- `m0_wdata` input 16: port 0 write data. Stable while `m0_req` is high.
- `m0_rdata` output 16: port 0 read data; valid while `m0_ack` is high.
- `m0_ack` output 1: port 0 completion; one-cycle pulse.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_rdata`, `m1_ack`: same as port 0, for port 1.
- `io_addr` output 8: address to the I/O block.
- `io_wdata` output 16: write data to the I/O block.
- `io_we` output 1: write enable to the I/O block.
- `io_rdata` input 16: combinational read data from the I/O block for `io_addr`.
- `busy` output 1: high while an access is in flight (ACCESS or ACK).

## Operation
- FSM states: IDLE, ACCESS, ACK. Reset state is IDLE.
- **IDLE**:
  - If neither `req` is high, stay in IDLE.
  - Otherwise select the grant `g`:
    - Only one `req` high: that port wins.
    - Both high with `FIXED_PRIORITY=1`: port 0 wins.
    - Both high with `FIXED_PRIORITY=0`: the port not granted last wins.
  - At that edge, register `io_addr`←`mg_addr` and `io_wdata`←`mg_wdata`, set `io_we`←`mg_we`, and go to ACCESS.
- **ACCESS** (exactly one cycle):
  - `io_we` is high only in this cycle, and only for writes. The I/O block captures the write on the edge that ends ACCESS.
  - For reads, `io_rdata` is sampled on the edge that ends ACCESS into `mg_rdata`.
  - At that edge `io_we`←0; go to ACK.
- **ACK** (exactly one cycle):
  - `mg_ack`=1. The other port's ack stays 0.
  - Last-grant register←`g`; go to IDLE.
- The requester drops `req` on the edge where it samples `ack`=1. A `req` still high in the following IDLE cycle is a new request.
- `mX_rdata` updates only on read completions for that port; it holds its value otherwise, including across writes.
- `io_addr` and `io_wdata` hold their last values between accesses.
- A request that is not granted waits. No requester may drop `req` before its `ack`; doing so is a protocol violation and the behaviour is undefined.
- `busy` = (state != IDLE), decoded from registered state.
- Reset values:
  - State IDLE; last-grant = port 1, so port 0 wins the first round-robin tie.
  - `io_we`=0, `io_addr`=0x00, `io_wdata`=0x0000.
  - `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0x0000, `busy`=0.
- Reset asserted mid-access: every register clears immediately and asynchronously, so `io_we` falls without waiting for a clock edge. No ack is issued for the aborted access. A requester still holding `req` is re-arbitrated normally after `reset_n` is released.

## Timing
- Access latency: `req` sampled high in IDLE at edge N; ACCESS occupies cycle N→N+1; `ack` is high in cycle N+1→N+2.
- Throughput: one access per 3 cycles. Continuous requests from both ports give 6 cycles per port-0/port-1 pair under round-robin.
- `io_we` is a single-cycle pulse per write, never asserted for two consecutive cycles.
- Read data path: `io_rdata` has a combinational path from `io_addr` within the ACCESS cycle; `mX_rdata` is registered.
- All outputs are driven from registers. The only combinational output term is the `busy` state decode.

## Test plan
- Reset: assert `reset_n`=0 in any state → all outputs 0, `busy`=0; after release with no requests the FSM stays in IDLE and `io_we` stays 0.
- Port 0 write `m0_addr`=0x10, `m0_wdata`=0xA5A5 → one cycle later `io_we`=1 for exactly one cycle with `io_addr`=0x10 and `io_wdata`=0xA5A5; `m0_ack` pulses in the following cycle; `m1_ack` stays 0.
- Port 1 read `m1_addr`=0x00 with the bench driving `io_rdata`=0x1234 during ACCESS → `io_we` stays 0; `m1_rdata`=0x1234 while `m1_ack`=1 and held afterwards; `m0_rdata` unchanged.
- Both ports requesting continuously with `FIXED_PRIORITY=0` → grants alternate 0,1,0,1 starting with port 0, one ack every 3 cycles. With `FIXED_PRIORITY=1` → port 0 granted every time and port 1 never granted while `m0_req` stays high.
- `reset_n` driven low during ACCESS of a port 0 write → `io_we` drops before the next clock edge; no `m0_ack`. After release with `m0_req` still high → the write is re-issued and completes with `m0_ack`.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the on-board I/O bus between the CPU (port 0) and a secondary master (port 1).
// Accesses are serialised one at a time through IDLE -> ACCESS -> ACK with round-robin or port-0 priority.
module io_bus_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_ack,
    output logic [7:0]  io_addr,
    output logic [15:0] io_wdata,
    output logic        io_we,
    input  logic [15:0] io_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t state_r;
    logic   grant_r;
    logic   last_grant_r;
    logic   grant_s;
    logic   any_req_s;

    // Grant choice for the IDLE cycle; a tie goes to port 0 or to the port not served last.
    always_comb begin
        grant_s   = 1'b0;
        any_req_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
            if (FIXED_PRIORITY) begin
                grant_s = 1'b0;
            end else begin
                grant_s = ~last_grant_r;
            end
        end else if (m1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Access sequencer: launches the bus cycle, captures read data and pulses the winner's ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            io_addr      <= 8'h00;
            io_wdata     <= 16'h0000;
            io_we        <= 1'b0;
            m0_rdata     <= 16'h0000;
            m1_rdata     <= 16'h0000;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (any_req_s) begin
                        grant_r  <= grant_s;
                        io_addr  <= grant_s ? m1_addr  : m0_addr;
                        io_wdata <= grant_s ? m1_wdata : m0_wdata;
                        io_we    <= grant_s ? m1_we    : m0_we;
                        state_r  <= ST_ACCESS;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // io_we still reflects the access type here, so it doubles as the read/write flag.
                    if (!io_we) begin
                        if (grant_r) begin
                            m1_rdata <= io_rdata;
                        end else begin
                            m0_rdata <= io_rdata;
                        end
                    end
                    io_we   <= 1'b0;
                    m0_ack  <= ~grant_r;
                    m1_ack  <= grant_r;
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    m0_ack       <= 1'b0;
                    m1_ack       <= 1'b0;
                    last_grant_r <= grant_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    io_we   <= 1'b0;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: a round-robin and a fixed-priority instance share stimulus,
// expected accesses are queued and checked as the selected instance acknowledges them.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0]  m0_addr = 8'h00, m1_addr = 8'h00;
    logic [15:0] m0_wdata = 16'h0000, m1_wdata = 16'h0000;

    logic [15:0] rr_m0_rdata, rr_m1_rdata, rr_io_wdata, rr_io_rdata;
    logic [15:0] fp_m0_rdata, fp_m1_rdata, fp_io_wdata, fp_io_rdata;
    logic [7:0]  rr_io_addr, fp_io_addr;
    logic        rr_m0_ack, rr_m1_ack, rr_io_we, rr_busy;
    logic        fp_m0_ack, fp_m1_ack, fp_io_we, fp_busy;

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    int          ack_cyc_q[$];
    int          ntot = 0;
    int          nbad = 0;
    logic [15:0] exp_rd0 = 16'h0000;
    logic [15:0] exp_rd1 = 16'h0000;

    // I/O block read model: any address maps to a distinct pattern, 0x00 -> 0x1234.
    function automatic logic [15:0] rd_fn(input logic [7:0] a);
        return 16'h1234 ^ {a, a};
    endfunction

    assign rr_io_rdata = rd_fn(rr_io_addr);
    assign fp_io_rdata = rd_fn(fp_io_addr);

    always #5 clk = ~clk;

    io_bus_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(rr_m0_rdata), .m0_ack(rr_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(rr_m1_rdata), .m1_ack(rr_m1_ack),
        .io_addr(rr_io_addr), .io_wdata(rr_io_wdata), .io_we(rr_io_we),
        .io_rdata(rr_io_rdata), .busy(rr_busy)
    );

    io_bus_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(fp_m0_rdata), .m0_ack(fp_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(fp_m1_rdata), .m1_ack(fp_m1_ack),
        .io_addr(fp_io_addr), .io_wdata(fp_io_wdata), .io_we(fp_io_we),
        .io_rdata(fp_io_rdata), .busy(fp_busy)
    );

    task automatic push_exp(input logic p, input logic w, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        e.port = p; e.we = w; e.addr = a; e.wdata = d;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        exp_rd0 = 16'h0000; exp_rd1 = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard drain: compares bus writes and acks of the selected instance against the queue.
    task automatic drain(input bit fp, input bit drop_req, input int max_cyc);
        exp_t        e;
        logic        o_we, o_ack0, o_ack1, prev_we;
        logic [7:0]  o_addr;
        logic [15:0] o_wdata, o_rd0, o_rd1;
        int          cyc;
        prev_we = 1'b0;
        cyc = 0;
        ack_cyc_q.delete();
        while (sb_q.size() != 0) begin
            if (cyc >= max_cyc) begin
                ntot++; nbad++;
                $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
                sb_q.delete();
                break;
            end
            @(negedge clk);
            cyc++;
            o_we    = fp ? fp_io_we    : rr_io_we;
            o_addr  = fp ? fp_io_addr  : rr_io_addr;
            o_wdata = fp ? fp_io_wdata : rr_io_wdata;
            o_ack0  = fp ? fp_m0_ack   : rr_m0_ack;
            o_ack1  = fp ? fp_m1_ack   : rr_m1_ack;
            o_rd0   = fp ? fp_m0_rdata : rr_m0_rdata;
            o_rd1   = fp ? fp_m1_rdata : rr_m1_rdata;
            if (o_we === 1'b1) begin
                ntot++;
                if (prev_we !== 1'b0 || sb_q[0].we !== 1'b1 || o_addr !== sb_q[0].addr || o_wdata !== sb_q[0].wdata) begin
                    nbad++;
                    $display("FAIL bus_write: got prev_we=%b addr=%h wdata=%h, required prev_we=0 we=%b addr=%h wdata=%h",
                             prev_we, o_addr, o_wdata, sb_q[0].we, sb_q[0].addr, sb_q[0].wdata);
                end
            end
            prev_we = o_we;
            if (o_ack0 !== 1'b0 || o_ack1 !== 1'b0) begin
                e = sb_q.pop_front();
                ack_cyc_q.push_back(cyc);
                ntot++;
                if ({o_ack0, o_ack1} !== (e.port ? 2'b01 : 2'b10)) begin
                    nbad++;
                    $display("FAIL ack_port: got ack0=%b ack1=%b, required port %0d only", o_ack0, o_ack1, e.port);
                end
                if (!e.we) begin
                    if (e.port) exp_rd1 = rd_fn(e.addr);
                    else        exp_rd0 = rd_fn(e.addr);
                end
                ntot++;
                if (o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
                    nbad++;
                    $display("FAIL ack_rdata: got rd0=%h rd1=%h, required rd0=%h rd1=%h", o_rd0, o_rd1, exp_rd0, exp_rd1);
                end
                if (drop_req) begin
                    @(posedge clk);
                    #1;
                    if (e.port) m1_req = 1'b0;
                    else        m0_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        ntot++;
        if ({rr_io_we, rr_m0_ack, rr_m1_ack, rr_busy} !== 4'b0000 || rr_io_addr !== 8'h00 ||
            rr_io_wdata !== 16'h0000 || rr_m0_rdata !== 16'h0000 || rr_m1_rdata !== 16'h0000) begin
            nbad++;
            $display("FAIL reset_values: got we=%b ack0=%b ack1=%b busy=%b addr=%h wdata=%h rd0=%h rd1=%h, required all zero",
                     rr_io_we, rr_m0_ack, rr_m1_ack, rr_busy, rr_io_addr, rr_io_wdata, rr_m0_rdata, rr_m1_rdata);
        end
        apply_reset();
        repeat (5) begin
            @(negedge clk);
            ntot++;
            if (rr_io_we !== 1'b0 || rr_busy !== 1'b0) begin
                nbad++;
                $display("FAIL reset_idle: got io_we=%b busy=%b, required 0 0", rr_io_we, rr_busy);
            end
        end
    endtask

    task automatic test_write_p0();
        @(posedge clk); #1;
        m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 16'hA5A5; m0_req = 1'b1;
        push_exp(1'b0, 1'b1, 8'h10, 16'hA5A5);
        drain(1'b0, 1'b1, 10);
        ntot++;
        if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 3) begin
            nbad++;
            $display("FAIL write_latency: got %0d acks first at cycle %0d, required 1 ack at cycle 3",
                     ack_cyc_q.size(), (ack_cyc_q.size() != 0) ? ack_cyc_q[0] : -1);
        end
    endtask

    task automatic test_read_p1();
        @(posedge clk); #1;
        m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 16'hFFFF; m1_req = 1'b1;
        push_exp(1'b1, 1'b0, 8'h00, 16'hFFFF);
        drain(1'b0, 1'b1, 10);
        repeat (2) @(negedge clk);
        ntot++;
        if (rr_m1_rdata !== 16'h1234 || rr_m0_rdata !== 16'h0000 || rr_io_we !== 1'b0) begin
            nbad++;
            $display("FAIL read_hold: got m1_rdata=%h m0_rdata=%h io_we=%b, required 1234 0000 0",
                     rr_m1_rdata, rr_m0_rdata, rr_io_we);
        end
    endtask

    task automatic test_contention(input bit fp);
        apply_reset();
        @(posedge clk); #1;
        m0_we = 1'b1; m0_addr = 8'h20; m0_wdata = 16'h1111;
        m1_we = 1'b0; m1_addr = 8'h30; m1_wdata = 16'h2222;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (fp || (i % 2) == 0) push_exp(1'b0, 1'b1, 8'h20, 16'h1111);
            else                    push_exp(1'b1, 1'b0, 8'h30, 16'h2222);
        end
        drain(fp, 1'b0, 20);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ntot++;
            if (ack_cyc_q.size() <= i || ack_cyc_q[i] != 3 * (i + 1)) begin
                nbad++;
                $display("FAIL contention_spacing fp=%0d ack %0d: got cycle %0d, required %0d",
                         fp, i, (ack_cyc_q.size() > i) ? ack_cyc_q[i] : -1, 3 * (i + 1));
            end
        end
        repeat (3) @(negedge clk);
        ntot++;
        if ((fp ? fp_busy : rr_busy) !== 1'b0) begin
            nbad++;
            $display("FAIL contention_idle fp=%0d: got busy=1, required 0", fp);
        end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        @(posedge clk); #1;
        m0_we = 1'b1; m0_addr = 8'h40; m0_wdata = 16'hBEEF; m0_req = 1'b1;
        @(posedge clk); #2;
        ntot++;
        if (rr_io_we !== 1'b1) begin
            nbad++;
            $display("FAIL abort_pre: got io_we=%b, required 1", rr_io_we);
        end
        reset_n = 1'b0;
        #1;
        ntot++;
        if (rr_io_we !== 1'b0 || rr_busy !== 1'b0 || rr_m0_ack !== 1'b0) begin
            nbad++;
            $display("FAIL abort_async: got io_we=%b busy=%b m0_ack=%b, required 0 0 0", rr_io_we, rr_busy, rr_m0_ack);
        end
        @(posedge clk);
        @(negedge clk);
        ntot++;
        if (rr_m0_ack !== 1'b0) begin
            nbad++;
            $display("FAIL abort_noack: got m0_ack=%b, required 0", rr_m0_ack);
        end
        reset_n = 1'b1;
        push_exp(1'b0, 1'b1, 8'h40, 16'hBEEF);
        drain(1'b0, 1'b1, 10);
        ntot++;
        if (ack_cyc_q.size() != 1) begin
            nbad++;
            $display("FAIL abort_reissue: got %0d acks, required 1", ack_cyc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_p1();
        test_contention(1'b0);
        test_contention(1'b1);
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
